// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the runner game: state encoding and scroll-speed width.
// Ground and Jump import the same package.
package game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int SPEED_W = 4;

endpackage

// File: rtl/game_ctrl_bcd_counter4.sv
// 4-digit BCD score counter: saturates at 9999, synchronous clear, async reset.
module bcd_counter4 (
    input  logic        clk,
    input  logic        clrn,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] q_inc;
    logic        carry;

    // Ripple the +1 through the digits; a 9 rolls to 0 and passes the carry up.
    always_comb begin
        q_inc = q;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (q[i*4 +: 4] == 4'd9) begin
                    q_inc[i*4 +: 4] = 4'd0;
                end else begin
                    q_inc[i*4 +: 4] = q[i*4 +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                        q <= 16'h0000;
        else if (clr)                     q <= 16'h0000;
        else if (en && q != 16'h9999)     q <= q_inc;
    end

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: IDLE/RUN/OVER sequencing, frame-based collision check,
// speed ramp and BCD score for the dinosaur runner.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int SPEED_INIT      = 1,
    parameter int SPEED_MAX       = 15,
    parameter int FRAMES_PER_STEP = 600,
    parameter int SCORE_DIV       = 6,
    parameter int OVER_HOLD       = 30
) (
    input  logic               CLK,
    input  logic               clrn,
    input  logic               start,
    input  logic               fresh,
    input  logic               px_dinosaur,
    input  logic               px_obstacle,
    output logic               game_status,
    output logic               game_over,
    output logic [SPEED_W-1:0] speed,
    output logic [15:0]        score
);

    localparam int DIV_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int HOLD_W = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCORE_DIV - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(OVER_HOLD);
    localparam logic [SPEED_W-1:0] SPD_INIT  = SPEED_W'(SPEED_INIT);
    localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(SPEED_MAX);

    // [0],[1] synchronize, [2] holds the previous synced value for edge detect
    logic [2:0] start_sync, fresh_sync;
    logic       start_pe, frame_pe;

    state_t              state, state_next;
    logic                run_entry, over_entry, frame_run;
    logic                coll;
    logic [DIV_W-1:0]    div_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                score_tick, step_tick;

    assign start_pe   = start_sync[1] & ~start_sync[2];
    assign frame_pe   = fresh_sync[1] & ~fresh_sync[2];
    assign score_tick = frame_run && (div_cnt == DIV_LAST);
    assign step_tick  = frame_run && (step_cnt == STEP_LAST);

    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        run_entry  = 1'b0;
        over_entry = 1'b0;
        frame_run  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_pe) begin
                    state_next = ST_RUN;
                    run_entry  = 1'b1;
                end
            end
            ST_RUN: begin
                if (frame_pe) begin
                    if (coll) begin
                        state_next = ST_OVER;
                        over_entry = 1'b1;
                    end else begin
                        frame_run  = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (start_pe && hold_cnt >= HOLD_MAX) begin
                    state_next = ST_RUN;
                    run_entry  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge clrn) begin
        if (!clrn) begin
            start_sync  <= 3'b000;
            fresh_sync  <= 3'b000;
            game_status <= 1'b0;
            game_over   <= 1'b0;
            coll        <= 1'b0;
            div_cnt     <= '0;
            step_cnt    <= '0;
            hold_cnt    <= '0;
            speed       <= SPD_INIT;
        end else begin
            start_sync  <= {start_sync[1:0], start};
            fresh_sync  <= {fresh_sync[1:0], fresh};
            game_status <= (state == ST_RUN);
            game_over   <= (state == ST_OVER);

            // Overlap wins over the frame clear: it belongs to the new frame.
            if (state == ST_RUN && px_dinosaur && px_obstacle) coll <= 1'b1;
            else if (frame_pe || run_entry)                    coll <= 1'b0;

            if (run_entry) begin
                div_cnt  <= '0;
                step_cnt <= '0;
                speed    <= SPD_INIT;
            end else if (frame_run) begin
                div_cnt  <= score_tick ? '0 : div_cnt + 1'b1;
                step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
                if (step_tick && speed < SPD_MAX) speed <= speed + 1'b1;
            end

            if (over_entry)
                hold_cnt <= '0;
            else if (state == ST_OVER && frame_pe && hold_cnt < HOLD_MAX)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    bcd_counter4 u_score (
        .clk  (CLK),
        .clrn (clrn),
        .clr  (run_entry),
        .en   (score_tick),
        .q    (score)
    );

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: four parameterizations share one stimulus stream;
// expected values are queued as stimulus is driven and popped at each check.
module tb_game_ctrl;

    logic CLK = 1'b0;
    logic clrn, start, fresh, px_d, px_o;

    logic        a_st, a_ov, b_st, b_ov, c_st, c_ov, d_st, d_ov;
    logic [3:0]  a_sp, b_sp, c_sp, d_sp;
    logic [15:0] a_sc, b_sc, c_sc, d_sc;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_t;

    sb_t sb[$];
    int  passed = 0;
    int  total  = 0;

    always #5 CLK = ~CLK;

    game_ctrl u_a (
        .CLK(CLK), .clrn(clrn), .start(start), .fresh(fresh),
        .px_dinosaur(px_d), .px_obstacle(px_o),
        .game_status(a_st), .game_over(a_ov), .speed(a_sp), .score(a_sc));

    game_ctrl #(.FRAMES_PER_STEP(4)) u_b (
        .CLK(CLK), .clrn(clrn), .start(start), .fresh(fresh),
        .px_dinosaur(px_d), .px_obstacle(px_o),
        .game_status(b_st), .game_over(b_ov), .speed(b_sp), .score(b_sc));

    game_ctrl #(.FRAMES_PER_STEP(4), .SPEED_INIT(14)) u_c (
        .CLK(CLK), .clrn(clrn), .start(start), .fresh(fresh),
        .px_dinosaur(px_d), .px_obstacle(px_o),
        .game_status(c_st), .game_over(c_ov), .speed(c_sp), .score(c_sc));

    game_ctrl #(.SCORE_DIV(1)) u_d (
        .CLK(CLK), .clrn(clrn), .start(start), .fresh(fresh),
        .px_dinosaur(px_d), .px_obstacle(px_o),
        .game_status(d_st), .game_over(d_ov), .speed(d_sp), .score(d_sc));

    task automatic push(input string tag, input logic [15:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [15:0] obs);
        sb_t e;
        total++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: observed %h, nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) passed++;
            else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    // One frame: fresh high 2 clocks, low 2; ovl places the overlap on the frame_pe cycle.
    task automatic frame(input logic ovl);
        @(negedge CLK) fresh = 1'b1;
        @(negedge CLK);
        @(negedge CLK) begin fresh = 1'b0; px_d = ovl; px_o = ovl; end
        @(negedge CLK) begin px_d = 1'b0; px_o = 1'b0; end
        @(negedge CLK);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0);
    endtask

    task automatic start_pulse();
        @(negedge CLK) start = 1'b1;
        repeat (4) @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK) clrn = 1'b0;
        repeat (2) @(negedge CLK);
        clrn = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        clrn = 1'b0; start = 1'b0; fresh = 1'b0; px_d = 1'b0; px_o = 1'b0;
        repeat (3) @(negedge CLK);
        clrn = 1'b1;

        // Reset then idle
        push("idle_status", 16'd0); push("idle_over", 16'd0);
        push("idle_score", 16'h0000); push("idle_speed", 16'd1);
        frames(5);
        chk(a_st); chk(a_ov); chk(a_sc); chk(a_sp);

        // Start latency: RUN visible after edge n+3
        push("lat_n2", 16'd0); push("lat_n3", 16'd1);
        @(negedge CLK) start = 1'b1;
        repeat (3) @(posedge CLK);
        #1 chk(a_st);
        @(posedge CLK);
        #1 chk(a_st);
        @(negedge CLK) start = 1'b0;

        push("score_12f", 16'h0002); push("d_score_12f", 16'h0012);
        frames(12);
        chk(a_sc); chk(d_sc);

        push("b_speed_20f", 16'd6); push("c_speed_sat", 16'd15); push("a_speed_20f", 16'd1);
        frames(8);
        chk(b_sp); chk(c_sp); chk(a_sp);

        // Collision mid-frame 7
        do_reset();
        start_pulse();
        frames(6);
        @(negedge CLK) begin px_d = 1'b1; px_o = 1'b1; end
        @(negedge CLK) begin px_d = 1'b0; px_o = 1'b0; end
        push("coll_over", 16'd1); push("coll_status", 16'd0);
        push("coll_score", 16'h0001); push("coll_b_speed", 16'd2); push("coll_d_score", 16'h0006);
        frame(1'b0);
        chk(a_ov); chk(a_st); chk(a_sc); chk(b_sp); chk(d_sc);

        // Holdoff in OVER
        frames(10);
        push("hold10_over", 16'd1); push("hold10_score", 16'h0001); push("hold10_b_speed", 16'd2);
        start_pulse();
        chk(a_ov); chk(a_sc); chk(b_sp);
        frames(19);
        push("hold29_over", 16'd1);
        start_pulse();
        chk(a_ov);
        frames(2);
        push("hold31_status", 16'd1); push("hold31_over", 16'd0);
        push("hold31_score", 16'h0000); push("hold31_speed", 16'd1); push("hold31_b_speed", 16'd1);
        start_pulse();
        chk(a_st); chk(a_ov); chk(a_sc); chk(a_sp); chk(b_sp);

        // Overlap on the frame_pe cycle: OVER only at the following frame
        push("coin_status", 16'd1); push("coin_over", 16'd0);
        frame(1'b1);
        chk(a_st); chk(a_ov);
        push("coin_next_over", 16'd1); push("coin_next_status", 16'd0); push("coin_next_score", 16'h0000);
        frame(1'b0);
        chk(a_ov); chk(a_st); chk(a_sc);

        // Asynchronous reset mid-RUN
        do_reset();
        start_pulse();
        push("pre_rst_status", 16'd1); push("pre_rst_score", 16'h0001);
        frames(6);
        chk(a_st); chk(a_sc);
        push("rst_flags", 16'h0000); push("rst_speeds", 16'h1E11);
        push("rst_a_score", 16'h0000); push("rst_b_score", 16'h0000);
        push("rst_c_score", 16'h0000); push("rst_d_score", 16'h0000);
        @(posedge CLK);
        #2 clrn = 1'b0;
        #1;
        chk({8'h00, a_st, a_ov, b_st, b_ov, c_st, c_ov, d_st, d_ov});
        chk({b_sp, c_sp, d_sp, a_sp});
        chk(a_sc); chk(b_sc); chk(c_sc); chk(d_sc);
        @(negedge CLK) clrn = 1'b1;
        repeat (2) @(negedge CLK);

        // Score saturation with SCORE_DIV=1
        start_pulse();
        push("d_score_9998", 16'h9998);
        frames(9998);
        chk(d_sc);
        push("d_score_sat", 16'h9999); push("d_status_sat", 16'd1);
        frames(3);
        chk(d_sc); chk(d_st);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Game-flow controller for the dinosaur runner. It sits directly upstream of Ground and Jump, and drives the game_status and speed nets that feed them. It consumes the per-pixel dinosaur and obstacle masks from the render stages and the vs frame strobe to detect collisions. It runs the IDLE/RUN/OVER state machine, ramps speed over time and keeps a 4-digit BCD score for display.

Parameters:
SPEED_INIT, 1, speed loaded on every game start (4-bit)
SPEED_MAX, 15, speed saturation value
FRAMES_PER_STEP, 600, RUN frames between speed increments
SCORE_DIV, 6, RUN frames per score point
OVER_HOLD, 30, frames after entering OVER during which start is ignored

Ports:
CLK  input  1  system clock, all logic on posedge
clrn  input  1  asynchronous active-low reset
start  input  1  raw start button (asynchronous, level)
fresh  input  1  vs from Vga; frame boundary = rising edge
px_dinosaur  input  1  dinosaur pixel mask at current row_addr/col_addr
px_obstacle  input  1  obstacle pixel mask at same pixel
game_status  output  1  1 = RUN, else 0
game_over  output  1  1 in OVER
speed  output  4  current scroll speed
score  output  16  4-digit BCD score, [15:12] = thousands

Behaviour:
- Reset (clrn=0, asynchronous): state=IDLE, game_status=0, game_over=0, speed=SPEED_INIT, score=0; all counters, synchronizers and the collision latch are cleared.
- start and fresh each pass through a 2-flop synchronizer, then an edge detector (prev flop).
  - start_pe = rising edge of synced start.
  - frame_pe = rising edge of synced fresh; 1-CLK pulse.
  - Latency: start rising before CLK edge n makes state=RUN visible after edge n+3.
- Collision latch: set in any CLK cycle where state=RUN and px_dinosaur & px_obstacle = 1. Cleared on frame_pe and on every entry to RUN.
  - If overlap and frame_pe occur in the same cycle, the overlap counts toward the new frame: the latch is set, not cleared.
- IDLE: outputs static. start_pe moves to RUN.
- RUN entry (from IDLE or OVER): score=0, speed=SPEED_INIT, frame counters=0, collision latch=0.
- RUN: on each frame_pe:
  - If the collision latch is set (value before this edge), go to OVER. No score or speed update on this frame.
  - Otherwise, increment score_div_cnt. When it reaches SCORE_DIV-1 it wraps to 0 and score increments by 1 BCD. Score saturates at 9999 with no wrap.
  - Also increment step_cnt. When it reaches FRAMES_PER_STEP-1 it wraps and speed = min(speed+1, SPEED_MAX).
  - start_pe is ignored in RUN.
- OVER: game_over=1, game_status=0; score and speed frozen. hold_cnt counts frame_pe up to OVER_HOLD.
  - start_pe while hold_cnt < OVER_HOLD is ignored.
  - start_pe afterwards moves to RUN.
- Illegal state encoding moves to IDLE on the next clock.
- game_status and game_over are registered and decoded from state, with no combinational input-to-output path.
- Counter widths: clog2 of each parameter.

Decomposition:
- Shared package: state encoding (ST_IDLE=0, ST_RUN=1, ST_OVER=2) and the speed width constant (4). Ground and Jump will also use these.
- One sub-module, bcd_counter4: 4-digit saturating BCD incrementer with synchronous clear and enable inputs, reset by clrn.

Test Plan:
- Reset then idle: clrn=0 pulse, 5 frames with no start → game_status=0, score=0x0000, speed=1.
- Start latency: start rises before edge n → game_status=1 after edge n+3. Run 12 frames with no overlap → score=0x0002.
- Speed ramp: FRAMES_PER_STEP=4 override, 20 collision-free frames → speed=6. With SPEED_INIT=14, same run → speed stays 15.
- Collision: overlap px_dinosaur=px_obstacle=1 for one CLK mid-frame 7 → next frame_pe gives game_over=1, game_status=0, score frozen at 0x0001.
- Holdoff: in OVER, start pulse at frame 10 after entry is ignored. Start pulse at frame 31 → RUN, score=0x0000, speed=1.
- Boundaries:
  - Overlap in the same cycle as frame_pe → OVER at the following frame_pe, not this one.
  - SCORE_DIV=1 run from 9998 → score holds at 0x9999.
  - clrn asserted mid-RUN → immediate IDLE, all outputs at reset values.
